// File: rtl/owire_ds_slave.sv
// 1-wire responder that emulates a DS18B20 on DQ: presence, Skip ROM, Convert T
// and Read Scratchpad, with the 16-bit temperature returned LSB first.
module owire_ds_slave #(
  parameter int FCLK       = 125,
  parameter int RST_MIN_US = 400,
  parameter int PD_WAIT_US = 70,
  parameter int PD_LEN_US  = 120,
  parameter int SAMPLE_US  = 30,
  parameter int TX_HOLD_US = 30,
  parameter int CONV_US    = 750
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dq_in,
  output logic        dq_oe,
  input  logic [15:0] temp_value,
  output logic [7:0]  cmd_last,
  output logic        conv_busy,
  output logic        rd_done,
  output logic        err
);

  localparam int CW = (FCLK > 1) ? $clog2(FCLK) : 1;
  localparam int TW = 16;

  typedef enum logic [2:0] {
    IDLE, PD_WAIT, PRESENCE, RX_ROM, RX_FUNC, CONVERT, TX_DATA
  } state_t;

  state_t state, state_n;

  logic          dq_m, dq_s, dq_d;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [9:0]    low_tmr;
  logic [TW-1:0] st_us, slot_us, conv_us, st_lim, slot_lim;
  logic          slot_on;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg, rx_byte;
  logic [15:0]   scratch;
  logic          fall, rise, bus_rst, slot_fall, rx_mode, tx_mode;
  logic          st_done, slot_end, rx_bit, byte_done, tx_last, tx_bit, conv_start;

  // Bus idles high, so the synchronizer resets to 1 to avoid a phantom edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) {dq_m, dq_s, dq_d} <= 3'b111;
    else     {dq_m, dq_s, dq_d} <= {dq_in, dq_m, dq_s};
  end

  assign tick = (tick_cnt == CW'(FCLK - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      low_tmr  <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
      if (fall)                                   low_tmr <= '0;
      else if (tick && !dq_s && low_tmr != 10'd1023) low_tmr <= low_tmr + 10'd1;
    end
  end

  assign fall      = dq_d & ~dq_s;
  assign rise      = ~dq_d & dq_s;
  assign bus_rst   = rise && (low_tmr >= 10'(RST_MIN_US));
  // Edges caused by our own pull-down are not master slots.
  assign slot_fall = fall && !dq_oe;
  assign rx_mode   = (state == RX_ROM) || (state == RX_FUNC);
  assign tx_mode   = (state == TX_DATA) || (state == CONVERT);
  assign st_lim    = (state == PD_WAIT) ? TW'(PD_WAIT_US) : TW'(PD_LEN_US);
  assign st_done   = tick && (st_us == st_lim - TW'(1));
  assign slot_lim  = tx_mode ? TW'(TX_HOLD_US) : TW'(SAMPLE_US);
  assign slot_end  = slot_on && tick && !slot_fall && (slot_us == slot_lim - TW'(1));
  assign rx_bit    = rx_mode && slot_end;
  assign rx_byte   = {dq_s, shreg[7:1]};
  assign byte_done = rx_bit && (bit_cnt == 4'd7);
  assign tx_last   = (state == TX_DATA) && slot_end && (bit_cnt == 4'd15);
  assign tx_bit    = (state == CONVERT) ? !conv_busy : scratch[bit_cnt];
  assign conv_start = byte_done && (state == RX_FUNC) && (rx_byte == 8'h44) && !bus_rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      PD_WAIT:  if (st_done) state_n = PRESENCE;
      PRESENCE: if (st_done) state_n = RX_ROM;
      RX_ROM:   if (byte_done) state_n = (rx_byte == 8'hCC) ? RX_FUNC : IDLE;
      RX_FUNC:  if (byte_done) begin
                  if (rx_byte == 8'h44)      state_n = CONVERT;
                  else if (rx_byte == 8'hBE) state_n = TX_DATA;
                  else                       state_n = IDLE;
                end
      TX_DATA:  if (tx_last) state_n = IDLE;
      default:  state_n = state;
    endcase
    if (bus_rst) state_n = PD_WAIT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_us     <= '0;
      slot_on   <= 1'b0;
      slot_us   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      cmd_last  <= '0;
      err       <= 1'b0;
      scratch   <= '0;
      conv_busy <= 1'b0;
      conv_us   <= '0;
      dq_oe     <= 1'b0;
      rd_done   <= 1'b0;
    end else begin
      if (bus_rst || state_n != state) st_us <= '0;
      else if (tick)                   st_us <= st_us + TW'(1);

      // One slot timer serves both write-bit sampling and read-0 hold.
      if (bus_rst)                           slot_on <= 1'b0;
      else if (slot_fall && (rx_mode || tx_mode)) begin
        slot_on <= 1'b1;
        slot_us <= '0;
      end else if (slot_end)                 slot_on <= 1'b0;
      else if (slot_on && tick)              slot_us <= slot_us + TW'(1);

      if (bus_rst || state_n != state)                      bit_cnt <= '0;
      else if (rx_bit || ((state == TX_DATA) && slot_end))  bit_cnt <= bit_cnt + 4'd1;

      if (rx_bit)    shreg    <= rx_byte;
      if (byte_done) cmd_last <= rx_byte;

      if (bus_rst)                             err <= 1'b0;
      else if (byte_done && state_n == IDLE)   err <= 1'b1;

      if (conv_start) scratch <= temp_value;

      // Conversion runs to completion regardless of bus resets.
      if (conv_start) begin
        conv_busy <= 1'b1;
        conv_us   <= '0;
      end else if (conv_busy && tick) begin
        if (conv_us == TW'(CONV_US - 1)) conv_busy <= 1'b0;
        conv_us <= conv_us + TW'(1);
      end

      if (bus_rst)                                  dq_oe <= 1'b0;
      else if ((state == PD_WAIT) && st_done)       dq_oe <= 1'b1;
      else if ((state == PRESENCE) && st_done)      dq_oe <= 1'b0;
      else if (tx_mode && slot_fall && !tx_bit)     dq_oe <= 1'b1;
      else if (tx_mode && slot_end)                 dq_oe <= 1'b0;

      rd_done <= tx_last && !bus_rst;
    end
  end

endmodule

// File: tb/tb_owire_ds_slave.sv
// Directed bench for owire_ds_slave: a wired-AND master model drives DQ and
// checks presence timing, command decode, conversion and scratchpad reads.
module tb_owire_ds_slave;
  localparam int F = 4;

  logic        clk = 1'b0;
  logic        rst, m_low, dq_in, dq_oe, conv_busy, rd_done, err;
  logic [15:0] temp_value;
  logic [7:0]  cmd_last;
  logic        rb;
  logic [15:0] w;
  int          n_chk = 0, n_err = 0, busy_cyc = 0, rd_cnt = 0, rd0 = 0, cnt = 0;

  always #5 clk = ~clk;

  // Open-drain bus: low if either side pulls.
  assign dq_in = ~(m_low | dq_oe);

  owire_ds_slave #(.FCLK(F)) dut (
    .clk(clk), .rst(rst), .dq_in(dq_in), .dq_oe(dq_oe), .temp_value(temp_value),
    .cmd_last(cmd_last), .conv_busy(conv_busy), .rd_done(rd_done), .err(err)
  );

  always @(negedge clk) begin
    if (conv_busy) busy_cyc <= busy_cyc + 1;
    if (rd_done)   rd_cnt   <= rd_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic wait_us(input int n);
    repeat (n * F) @(negedge clk);
  endtask

  task automatic write_bit(input logic b);
    m_low = 1'b1;
    wait_us(b ? 12 : 60);
    m_low = 1'b0;
    wait_us(b ? 58 : 10);
  endtask

  task automatic write_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) write_bit(v[i]);
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b1;
    wait_us(2);
    m_low = 1'b0;
    wait_us(3);
    b = dq_in;
    wait_us(60);
  endtask

  task automatic bus_reset(input string tag);
    int c;
    m_low = 1'b1;
    wait_us(480);
    m_low = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, "_rel"}, 32'(dq_oe), 32'd0);
    c = 3;
    while (!dq_oe && c < 100 * F) begin @(negedge clk); c++; end
    chk({tag, "_pd_dly"}, 32'(c >= 69 * F && c <= 71 * F), 32'd1);
    c = 0;
    while (dq_oe && c < 200 * F) begin @(negedge clk); c++; end
    chk({tag, "_pd_len"}, 32'(c), 32'(120 * F));
    wait_us(10);
  endtask

  initial begin
    rst = 1'b1;
    m_low = 1'b0;
    temp_value = 16'h0191;
    repeat (3) @(negedge clk);
    chk("rst_oe",   32'(dq_oe),     32'd0);
    chk("rst_cmd",  32'(cmd_last),  32'd0);
    chk("rst_busy", 32'(conv_busy), 32'd0);
    chk("rst_rdd",  32'(rd_done),   32'd0);
    chk("rst_err",  32'(err),       32'd0);
    rst = 1'b0;
    wait_us(5);
    read_bit(rb);
    chk("idle_rd", 32'(rb), 32'd1);

    // Convert T with busy/complete read slots
    bus_reset("r1");
    write_byte(8'hCC);
    chk("cmd_cc", 32'(cmd_last), 32'hCC);
    write_byte(8'h44);
    chk("cmd_44", 32'(cmd_last), 32'h44);
    chk("busy1",  32'(conv_busy), 32'd1);
    temp_value = 16'hBEEF;
    wait_us(60);
    read_bit(rb);
    chk("cv_rd100", 32'(rb), 32'd0);
    wait_us(635);
    read_bit(rb);
    chk("cv_rd800", 32'(rb), 32'd1);
    chk("busy0",    32'(conv_busy), 32'd0);
    chk("busy_len", 32'(busy_cyc), 32'(750 * F));
    chk("err_cv",   32'(err), 32'd0);

    // Read Scratchpad, full 16 bits
    bus_reset("r2");
    write_byte(8'hCC);
    write_byte(8'hBE);
    chk("cmd_be", 32'(cmd_last), 32'hBE);
    rd0 = rd_cnt;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      read_bit(rb);
      w[i] = rb;
      if (i == 14) chk("rd_early", 32'(rd_cnt - rd0), 32'd0);
    end
    chk("rd_word", 32'(w), 32'h0191);
    chk("rd_pulse", 32'(rd_cnt - rd0), 32'd1);

    // Unsupported ROM command
    bus_reset("r3");
    write_byte(8'h33);
    chk("err_set", 32'(err), 32'd1);
    chk("cmd_33",  32'(cmd_last), 32'h33);
    read_bit(rb);
    chk("err_rd",  32'(rb), 32'd1);
    write_byte(8'hCC);
    chk("err_nocmd", 32'(cmd_last), 32'h33);
    bus_reset("r4");
    chk("err_clr", 32'(err), 32'd0);

    // Bus reset mid-read restarts at bit 0
    write_byte(8'hCC);
    write_byte(8'hBE);
    w = '0;
    for (int i = 0; i < 9; i++) begin
      read_bit(rb);
      w[i] = rb;
    end
    chk("rd9", 32'(w), 32'h0191);
    bus_reset("r5");
    write_byte(8'hCC);
    write_byte(8'hBE);
    rd0 = rd_cnt;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      read_bit(rb);
      w[i] = rb;
    end
    chk("rd_word2",  32'(w), 32'h0191);
    chk("rd_pulse2", 32'(rd_cnt - rd0), 32'd1);

    // Async reset during presence
    m_low = 1'b1;
    wait_us(480);
    m_low = 1'b0;
    cnt = 0;
    while (!dq_oe && cnt < 100 * F) begin @(negedge clk); cnt++; end
    wait_us(20);
    chk("pres_on", 32'(dq_oe), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_oe",   32'(dq_oe),     32'd0);
    chk("arst_cmd",  32'(cmd_last),  32'd0);
    chk("arst_busy", 32'(conv_busy), 32'd0);
    chk("arst_err",  32'(err),       32'd0);
    chk("arst_rdd",  32'(rd_done),   32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_us(150);
    chk("post_rst", 32'(dq_oe), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
